// File: rtl/span_dispatch.sv
// Span scheduler between calcline and drawline: buffers spans in a small FIFO, issues them one
// at a time, and at each frame-block end drains the drawline write pipeline before handing off.
module span_dispatch #(
  parameter int DEPTH        = 4,
  parameter int AW           = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int DATA_W       = 161
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] span_data,
  output logic              span_start,
  input  logic              span_done,
  output logic              block_done,
  input  logic              block_ack,
  output logic              busy,
  output logic [AW:0]       fifo_level
);

  localparam int            CW         = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_RUN,
    S_DRAIN,
    S_BLOCK
  } state_t;

  state_t          state;
  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   drain_cnt;
  logic [DATA_W:0] head;
  logic            head_last;
  logic            push;
  logic            pop;

  // Full-ness depends on count alone, so a same-cycle pop never frees a slot for a push.
  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_RUN) && span_done && (count != '0);
  assign head       = mem[rd_ptr];
  assign head_last  = head[DATA_W];
  assign span_data  = (count == '0) ? '0 : head[DATA_W-1:0];
  assign busy       = (state != S_IDLE) || (count != '0);
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The head entry stays in the FIFO until drawline reports completion, keeping span_data stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      span_start <= 1'b0;
      block_done <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((count != '0) && span_done) begin
            span_start <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          span_start <= 1'b0;
          state      <= S_ACK;
        end
        S_ACK: begin
          if (!span_done) state <= S_RUN;
        end
        S_RUN: begin
          if (span_done) begin
            if (head_last) begin
              drain_cnt <= DRAIN_LOAD;
              state     <= S_DRAIN;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            block_done <= 1'b1;
            state      <= S_BLOCK;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        S_BLOCK: begin
          if (block_ack) begin
            block_done <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
